// File: rtl/z180_bus_pkg.sv
// ---------------------------------------------------------------------------
// z180_bus_pkg
// Shared definitions for the Z8S180 IO bus blocks:
//   DATA_W          - width of the CPU data bus
//   cyc_state_t     - IO bus-cycle FSM states
//   in_port_window  - true when an address lies inside a block of ports
// ---------------------------------------------------------------------------
package z180_bus_pkg;

    localparam int DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAITST = 2'd1,
        ACTIVE = 2'd2,
        DONE   = 2'd3
    } cyc_state_t;

    // Address lies in [base, base+num-1]; int arithmetic avoids 8-bit wrap.
    function automatic logic in_port_window(input logic [7:0] addr,
                                            input logic [7:0] base,
                                            input int         num);
        return (int'(addr) >= int'(base)) && (int'(addr) < int'(base) + num);
    endfunction

endpackage

// File: rtl/z180_io_cycle_fsm.sv
// ---------------------------------------------------------------------------
// z180_io_cycle_fsm
// One IO bus cycle sequencer: detects an access, optionally stretches it with
// /WAIT, then issues exactly one read or write tick per bus cycle.
// Ports:
//   phi, reset    - bus clock, synchronous active-high reset
//   hit           - /IORQ low and address inside the port window
//   rd, wr        - decoded /RD and /WR (active high)
//   idx           - port index of the current address
//   wait_n        - registered /WAIT, low while stretching the cycle
//   rd_tick       - read strobe fires at the coming edge
//   wr_tick       - write latch/strobe fires at the coming edge
//   tick_idx      - port index captured at detection
// ---------------------------------------------------------------------------
module z180_io_cycle_fsm
    import z180_bus_pkg::*;
#(
    parameter int WAIT_STATES = 0,
    parameter int WR_DELAY    = 1,
    parameter int IDX_W       = 2
) (
    input  logic             phi,
    input  logic             reset,
    input  logic             hit,
    input  logic             rd,
    input  logic             wr,
    input  logic [IDX_W-1:0] idx,
    output logic             wait_n,
    output logic             rd_tick,
    output logic             wr_tick,
    output logic [IDX_W-1:0] tick_idx
);

    cyc_state_t state, state_nx;
    logic [2:0] cnt, cnt_nx;
    logic       op_rd;
    logic       start;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge phi) begin
        if (reset) begin
            state    <= IDLE;
            cnt      <= '0;
            op_rd    <= 1'b0;
            tick_idx <= '0;
            wait_n   <= 1'b1;
        end else begin
            state  <= state_nx;
            cnt    <= cnt_nx;
            wait_n <= (state_nx != WAITST);
            if (start) begin
                // Read wins over a simultaneous write.
                op_rd    <= rd;
                tick_idx <= idx;
            end
        end
    end

    // NOTE: every output of this block gets a default first so no path
    // leaves a signal unassigned, which would infer a latch.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        start    = 1'b0;
        rd_tick  = 1'b0;
        wr_tick  = 1'b0;
        unique case (state)
            IDLE: begin
                if (hit && (rd || wr)) begin
                    start    = 1'b1;
                    cnt_nx   = '0;
                    state_nx = (WAIT_STATES > 0) ? WAITST : ACTIVE;
                end
            end
            WAITST: begin
                if (!hit) begin
                    state_nx = IDLE;
                    cnt_nx   = '0;
                end else if (cnt == 3'(WAIT_STATES - 1)) begin
                    state_nx = ACTIVE;
                    cnt_nx   = '0;
                end else begin
                    cnt_nx = cnt + 3'd1;
                end
            end
            ACTIVE: begin
                if (!hit) begin
                    // Aborted before the tick: nothing is strobed or latched.
                    state_nx = IDLE;
                    cnt_nx   = '0;
                end else if (op_rd) begin
                    rd_tick  = 1'b1;
                    state_nx = DONE;
                end else if (cnt == 3'(WR_DELAY)) begin
                    wr_tick  = 1'b1;
                    state_nx = DONE;
                    cnt_nx   = '0;
                end else begin
                    cnt_nx = cnt + 3'd1;
                end
            end
            DONE: begin
                // Hold until /IORQ releases so a long cycle gets one tick.
                if (!hit) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

endmodule

// File: rtl/z180_io_port_bank.sv
// ---------------------------------------------------------------------------
// z180_io_port_bank
// NUM_PORTS consecutive 8-bit IO ports at BASE_ADDR on the Z8S180 IO bus.
// Ports:
//   phi, reset            - bus clock, synchronous active-high reset
//   a, iorq_n, rd_n, wr_n - CPU address and IO control pins
//   din                   - CPU data bus as seen by the FPGA
//   in_data               - peripheral read values, port k in [8k+7:8k]
//   dout                  - read data to the CPU (00 when not driving)
//   dbus_out              - FPGA drives the data bus
//   wait_n                - CPU /WAIT (0 = stretch)
//   out_reg               - write latches, port k in [8k+7:8k]
//   wr_stb, rd_stb        - one-phi per-port write/read pulses
// ---------------------------------------------------------------------------
module z180_io_port_bank
    import z180_bus_pkg::*;
#(
    parameter int                   NUM_PORTS   = 4,
    parameter logic [7:0]           BASE_ADDR   = 8'hF0,
    parameter int                   WR_DELAY    = 1,
    parameter int                   WAIT_STATES = 0,
    parameter logic [NUM_PORTS-1:0] READBACK    = '0,
    parameter logic [DATA_W-1:0]    RESET_VAL   = 8'h00
) (
    input  logic                          phi,
    input  logic                          reset,
    input  logic [7:0]                    a,
    input  logic                          iorq_n,
    input  logic                          rd_n,
    input  logic                          wr_n,
    input  logic [DATA_W-1:0]             din,
    input  logic [DATA_W*NUM_PORTS-1:0]   in_data,
    output logic [DATA_W-1:0]             dout,
    output logic                          dbus_out,
    output logic                          wait_n,
    output logic [DATA_W*NUM_PORTS-1:0]   out_reg,
    output logic [NUM_PORTS-1:0]          wr_stb,
    output logic [NUM_PORTS-1:0]          rd_stb
);

    localparam int IDX_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

    logic                                hit, rd, wr;
    logic [IDX_W-1:0]                    idx, tick_idx;
    logic                                rd_tick, wr_tick;
    logic [NUM_PORTS-1:0][DATA_W-1:0]    regs;
    logic [NUM_PORTS-1:0][DATA_W-1:0]    in_arr;

    assign hit    = ~iorq_n && in_port_window(a, BASE_ADDR, NUM_PORTS);
    assign rd     = ~rd_n;
    assign wr     = ~wr_n;
    assign idx    = IDX_W'(a - BASE_ADDR);
    assign in_arr = in_data;
    assign out_reg = regs;

    // Combinational so the bus is driven early in T2, independent of the FSM.
    assign dbus_out = hit & rd & ~wr;

    always_comb begin
        dout = '0;
        if (dbus_out) dout = READBACK[idx] ? regs[idx] : in_arr[idx];
    end

    z180_io_cycle_fsm #(
        .WAIT_STATES (WAIT_STATES),
        .WR_DELAY    (WR_DELAY),
        .IDX_W       (IDX_W)
    ) u_fsm (
        .phi      (phi),
        .reset    (reset),
        .hit      (hit),
        .rd       (rd),
        .wr       (wr),
        .idx      (idx),
        .wait_n   (wait_n),
        .rd_tick  (rd_tick),
        .wr_tick  (wr_tick),
        .tick_idx (tick_idx)
    );

    // NOTE: the latch bank is a handful of flops with a defined power-up
    // value, so it is reset like any other register rather than treated as
    // an uninitialised memory.
    always_ff @(posedge phi) begin
        if (reset) begin
            regs   <= {NUM_PORTS{RESET_VAL}};
            wr_stb <= '0;
            rd_stb <= '0;
        end else begin
            wr_stb <= '0;
            rd_stb <= '0;
            if (wr_tick) begin
                regs[tick_idx]   <= din;
                wr_stb[tick_idx] <= 1'b1;
            end
            if (rd_tick) rd_stb[tick_idx] <= 1'b1;
        end
    end

endmodule

// File: tb/tb_z180_io_port_bank.sv
// ---------------------------------------------------------------------------
// tb_z180_io_port_bank
// Two instances share one bus: u0 without wait states, uw with three.
// Stimulus tasks push expected strobe events into per-instance queues; a
// negedge monitor pops and compares them as the DUTs produce strobes.
// ---------------------------------------------------------------------------
module tb_z180_io_port_bank;

    localparam int         NP   = 4;
    localparam logic [7:0] BASE = 8'hF0;
    localparam int         WRD  = 1;
    localparam int         WS_W = 3;
    localparam logic [3:0] RB   = 4'b1000;

    logic        phi = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  a = 8'h00;
    logic        iorq_n = 1'b1, rd_n = 1'b1, wr_n = 1'b1;
    logic [7:0]  din = 8'h00;
    logic [31:0] in_data = 32'h0;

    logic [7:0]  u0_dout, uw_dout;
    logic        u0_dbus, uw_dbus, u0_wait_n, uw_wait_n;
    logic [31:0] u0_out_reg, uw_out_reg;
    logic [3:0]  u0_wr_stb, uw_wr_stb, u0_rd_stb, uw_rd_stb;

    z180_io_port_bank #(.NUM_PORTS(NP), .BASE_ADDR(BASE), .WR_DELAY(WRD),
                        .WAIT_STATES(0), .READBACK(RB), .RESET_VAL(8'h00)) u0 (
        .phi(phi), .reset(reset), .a(a), .iorq_n(iorq_n), .rd_n(rd_n), .wr_n(wr_n),
        .din(din), .in_data(in_data), .dout(u0_dout), .dbus_out(u0_dbus),
        .wait_n(u0_wait_n), .out_reg(u0_out_reg), .wr_stb(u0_wr_stb), .rd_stb(u0_rd_stb)
    );

    z180_io_port_bank #(.NUM_PORTS(NP), .BASE_ADDR(BASE), .WR_DELAY(WRD),
                        .WAIT_STATES(WS_W), .READBACK(RB), .RESET_VAL(8'h00)) uw (
        .phi(phi), .reset(reset), .a(a), .iorq_n(iorq_n), .rd_n(rd_n), .wr_n(wr_n),
        .din(din), .in_data(in_data), .dout(uw_dout), .dbus_out(uw_dbus),
        .wait_n(uw_wait_n), .out_reg(uw_out_reg), .wr_stb(uw_wr_stb), .rd_stb(uw_rd_stb)
    );

    always #5 phi = ~phi;

    int cyc = 0;
    always @(posedge phi) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    typedef struct {
        bit          is_wr;
        int          idx;
        int          at;
        logic [31:0] regs;
    } exp_t;

    exp_t       q0[$];
    exp_t       q1[$];
    logic [7:0] mdl[2][4];
    logic [3:0] rb_mask = RB;
    int         w_lo = 1, w_hi = 0;
    bit         mon_en = 1'b0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s at cyc %0d: got=%h want=%h", name, cyc, got, want);
        end
    endtask

    function automatic logic [31:0] mdl_vec(input int d);
        logic [31:0] v;
        for (int i = 0; i < NP; i++) v[8*i +: 8] = mdl[d][i];
        return v;
    endfunction

    // One bus access, started on a negedge. hold = phi edges with /IORQ low.
    task automatic bus_cycle(input logic [7:0] addr, input logic [7:0] data,
                             input bit do_rd, input bit do_wr, input int hold, input int gap);
        int   c0       = cyc + 1;
        int   ia       = int'(addr);
        bit   hit      = (ia >= int'(BASE)) && (ia < int'(BASE) + NP);
        int   idx      = ia - int'(BASE);
        bit   is_write = do_wr && !do_rd;
        bit   exp_bus  = hit && do_rd && !do_wr;
        int   ws, lat, wlen;
        exp_t e;
        a = addr; din = data; iorq_n = 1'b0; rd_n = !do_rd; wr_n = !do_wr;
        if (hit && (do_rd || do_wr)) begin
            for (int d = 0; d < 2; d++) begin
                ws  = (d == 1) ? WS_W : 0;
                lat = 1 + ws + (is_write ? WRD : 0);
                if (d == 1) begin
                    wlen = (hold < ws) ? hold : ws;
                    w_lo = c0;
                    w_hi = c0 + wlen - 1;
                end
                if (hold >= lat + 1) begin
                    if (is_write) mdl[d][idx] = data;
                    e.is_wr = is_write; e.idx = idx; e.at = c0 + lat; e.regs = mdl_vec(d);
                    if (d == 0) q0.push_back(e); else q1.push_back(e);
                end
            end
        end
        #1;
        check("u0_dbus_out", {31'b0, u0_dbus}, {31'b0, exp_bus});
        check("uw_dbus_out", {31'b0, uw_dbus}, {31'b0, exp_bus});
        check("u0_dout", {24'b0, u0_dout},
              exp_bus ? {24'b0, (rb_mask[idx] ? mdl[0][idx] : in_data[8*idx +: 8])} : 32'h0);
        check("uw_dout", {24'b0, uw_dout},
              exp_bus ? {24'b0, (rb_mask[idx] ? mdl[1][idx] : in_data[8*idx +: 8])} : 32'h0);
        repeat (hold) @(negedge phi);
        iorq_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1;
        repeat (gap) @(negedge phi);
    endtask

    // Start a write, enter WAITST in uw, then reset for one edge with /IORQ low.
    task automatic reset_in_waitst();
        int c0 = cyc + 1;
        a = 8'hF0; din = 8'h3C; iorq_n = 1'b0; rd_n = 1'b1; wr_n = 1'b0;
        w_lo = c0; w_hi = c0;
        @(negedge phi);
        reset = 1'b1;
        @(negedge phi);
        #1;
        check("rst_waitst_wait_n", {31'b0, uw_wait_n}, 32'h1);
        check("rst_waitst_uw_out_reg", uw_out_reg, 32'h0);
        check("rst_waitst_u0_out_reg", u0_out_reg, 32'h0);
        for (int d = 0; d < 2; d++) for (int i = 0; i < NP; i++) mdl[d][i] = 8'h00;
        reset = 1'b0; iorq_n = 1'b1; wr_n = 1'b1;
        repeat (2) @(negedge phi);
    endtask

    task automatic mon(input int d, input logic [3:0] ws, input logic [3:0] rs,
                       input logic [31:0] oreg, input logic wn);
        exp_t e;
        bit   want_lo = (d == 1) && (cyc >= w_lo) && (cyc <= w_hi);
        bit   empty;
        check(d == 0 ? "u0_wait_n" : "uw_wait_n", {31'b0, wn}, {31'b0, !want_lo});
        empty = (d == 0) ? (q0.size() == 0) : (q1.size() == 0);
        if (!empty) begin
            e = (d == 0) ? q0[0] : q1[0];
            if (e.at < cyc) begin
                check("missed_strobe", cyc, e.at);
                if (d == 0) void'(q0.pop_front()); else void'(q1.pop_front());
            end
        end
        if (ws != 4'b0 || rs != 4'b0) begin
            empty = (d == 0) ? (q0.size() == 0) : (q1.size() == 0);
            if (empty) begin
                check("unexpected_strobe", {24'b0, ws, rs}, 32'h0);
            end else begin
                if (d == 0) e = q0.pop_front(); else e = q1.pop_front();
                check("strobe_cycle", cyc, e.at);
                check(e.is_wr ? "wr_stb" : "rd_stb", {28'b0, (e.is_wr ? ws : rs)}, 32'h1 << e.idx);
                check("other_stb", {28'b0, (e.is_wr ? rs : ws)}, 32'h0);
                if (e.is_wr) check("out_reg", oreg, e.regs);
            end
        end
    endtask

    always @(negedge phi) begin
        if (mon_en) begin
            mon(0, u0_wr_stb, u0_rd_stb, u0_out_reg, u0_wait_n);
            mon(1, uw_wr_stb, uw_rd_stb, uw_out_reg, uw_wait_n);
        end
    end

    initial begin
        int kind;
        logic [7:0] ra;
        for (int d = 0; d < 2; d++) for (int i = 0; i < NP; i++) mdl[d][i] = 8'h00;

        repeat (3) @(negedge phi);
        check("rst_u0_out_reg", u0_out_reg, 32'h0);
        check("rst_uw_out_reg", uw_out_reg, 32'h0);
        check("rst_strobes", {16'b0, u0_wr_stb, u0_rd_stb, uw_wr_stb, uw_rd_stb}, 32'h0);
        check("rst_wait_n", {30'b0, u0_wait_n, uw_wait_n}, 32'h3);
        reset = 1'b0;
        mon_en = 1'b1;

        // Directed cases.
        in_data = 32'h44_33_5C_11;
        bus_cycle(8'hF2, 8'hA5, 0, 1, 8, 1);   // write A5 -> port 2
        bus_cycle(8'hF1, 8'h00, 1, 0, 6, 1);   // read port 1 -> 5C
        bus_cycle(8'hF3, 8'h77, 0, 1, 8, 1);   // write port 3
        bus_cycle(8'hF3, 8'h00, 1, 0, 6, 1);   // readback of port 3 -> 77
        bus_cycle(8'hF0, 8'h96, 0, 1, 10, 1);  // long /IORQ, one strobe
        bus_cycle(8'hF1, 8'hEE, 0, 1, 2, 1);   // aborted before tick
        bus_cycle(8'hF4, 8'h12, 0, 1, 8, 1);   // miss above window
        bus_cycle(8'hEF, 8'h00, 1, 0, 6, 1);   // miss below window
        bus_cycle(8'hEF, 8'h34, 0, 1, 8, 1);
        bus_cycle(8'hF2, 8'h55, 1, 1, 6, 2);   // rd and wr together: read wins
        reset_in_waitst();

        // Randomised traffic.
        for (int n = 0; n < 150; n++) begin
            in_data = $urandom;
            ra = ($urandom_range(0, 3) == 0) ? 8'($urandom) : BASE + 8'($urandom_range(0, 3));
            kind = $urandom_range(0, 3);
            bus_cycle(ra, 8'($urandom), kind == 0 || kind == 2, kind != 0,
                      $urandom_range(1, 12), $urandom_range(1, 3));
        end

        repeat (20) @(negedge phi);
        check("u0_queue_drained", q0.size(), 32'h0);
        check("uw_queue_drained", q1.size(), 32'h0);
        check("u0_final_out_reg", u0_out_reg, mdl_vec(0));
        check("uw_final_out_reg", uw_out_reg, mdl_vec(1));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
